// File: rtl/cdb_arbiter_if.sv
// ---------------------------------------------------------------------------
// cdb_arbiter_if
//
// Purpose:
//   Bundles the functional-unit request side and the common data bus (CDB)
//   broadcast side of the CDB arbiter into one interface.
//
// Signals:
//   req_valid    N_FU              per-FU request, held until acknowledged
//   req_result   N_FU*DATA_WIDTH   per-FU result, FU i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_tag      N_FU*TAG_WIDTH    per-FU tag, packed the same way
//   req_dest     N_FU*5            per-FU destination register, packed the same way
//   req_ack      N_FU              one-hot (or zero) grant, combinational
//   cdb_stall    1                 consumer cannot take a broadcast next cycle
//   flush        1                 pipeline flush
//   cdb_valid    1                 registered broadcast valid
//   cdb_result   DATA_WIDTH        registered broadcast data
//   cdb_tag      TAG_WIDTH         registered broadcast tag
//   cdb_dest_reg 5                 registered broadcast destination register
//
// Modports:
//   master - the FU / consumer side (drives requests, stall and flush)
//   slave  - the arbiter side (drives acks and the broadcast)
// ---------------------------------------------------------------------------
interface cdb_arbiter_if #(
  parameter int N_FU       = 4,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 3
);

  logic [N_FU-1:0]            req_valid;
  logic [N_FU*DATA_WIDTH-1:0] req_result;
  logic [N_FU*TAG_WIDTH-1:0]  req_tag;
  logic [N_FU*5-1:0]          req_dest;
  logic [N_FU-1:0]            req_ack;
  logic                       cdb_stall;
  logic                       flush;
  logic                       cdb_valid;
  logic [DATA_WIDTH-1:0]      cdb_result;
  logic [TAG_WIDTH-1:0]       cdb_tag;
  logic [4:0]                 cdb_dest_reg;

  modport master (
    output req_valid,
    output req_result,
    output req_tag,
    output req_dest,
    output cdb_stall,
    output flush,
    input  req_ack,
    input  cdb_valid,
    input  cdb_result,
    input  cdb_tag,
    input  cdb_dest_reg
  );

  modport slave (
    input  req_valid,
    input  req_result,
    input  req_tag,
    input  req_dest,
    input  cdb_stall,
    input  flush,
    output req_ack,
    output cdb_valid,
    output cdb_result,
    output cdb_tag,
    output cdb_dest_reg
  );

endinterface : cdb_arbiter_if

// File: rtl/cdb_arbiter.sv
// ---------------------------------------------------------------------------
// cdb_arbiter
//
// Purpose:
//   Round-robin arbiter that picks one functional-unit result per cycle and
//   broadcasts it on the common data bus one cycle later. The grant (req_ack)
//   is combinational so a request can be accepted in the cycle it appears;
//   the broadcast fields are registered.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - cdb_arbiter_if.slave: FU requests in, acks and CDB broadcast out
//
// Parameters:
//   N_FU       - number of requesting functional units (2..8)
//   DATA_WIDTH - result width
//   TAG_WIDTH  - ROB/RS tag width
// ---------------------------------------------------------------------------
module cdb_arbiter #(
  parameter int N_FU       = 4,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 3
) (
  input  logic           clk,
  input  logic           rst,
  cdb_arbiter_if.slave   bus
);

  localparam int PTR_W = (N_FU > 1) ? $clog2(N_FU) : 1;
  // One extra bit so rr_ptr + offset never overflows before the wrap.
  localparam int IDX_W = PTR_W + 1;
  localparam logic [IDX_W-1:0] N_FU_IDX = IDX_W'(N_FU);
  localparam logic [PTR_W-1:0] LAST_FU  = PTR_W'(N_FU - 1);

  // Registered state
  logic [PTR_W-1:0]      rr_ptr_q,     rr_ptr_d;
  logic                  cdb_valid_q,  cdb_valid_d;
  logic [DATA_WIDTH-1:0] cdb_result_q, cdb_result_d;
  logic [TAG_WIDTH-1:0]  cdb_tag_q,    cdb_tag_d;
  logic [4:0]            cdb_dest_q,   cdb_dest_d;

  // Arbitration
  logic                  grant_any;
  logic [PTR_W-1:0]      grant_idx;
  logic [N_FU-1:0]       grant_oh;
  logic [IDX_W-1:0]      scan_idx;

  // Per-FU fields unpacked from the flat request buses
  logic [DATA_WIDTH-1:0] fu_result [N_FU];
  logic [TAG_WIDTH-1:0]  fu_tag    [N_FU];
  logic [4:0]            fu_dest   [N_FU];

  // Granted FU's fields
  logic [DATA_WIDTH-1:0] sel_result;
  logic [TAG_WIDTH-1:0]  sel_tag;
  logic [4:0]            sel_dest;

  genvar gi;
  generate
    for (gi = 0; gi < N_FU; gi++) begin : g_unpack
      assign fu_result[gi] = bus.req_result[gi*DATA_WIDTH +: DATA_WIDTH];
      assign fu_tag[gi]    = bus.req_tag[gi*TAG_WIDTH +: TAG_WIDTH];
      assign fu_dest[gi]   = bus.req_dest[gi*5 +: 5];
    end
  endgenerate

  // Scan FUs starting at rr_ptr and wrapping; the first valid one wins.
  // Reset, stall and flush all suppress the grant entirely, so nothing
  // downstream needs to re-qualify grant_any.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    if (!rst && !bus.cdb_stall && !bus.flush) begin
      for (int k = 0; k < N_FU; k++) begin
        scan_idx = {1'b0, rr_ptr_q} + IDX_W'(k);
        if (scan_idx >= N_FU_IDX) begin
          scan_idx = scan_idx - N_FU_IDX;
        end
        if (!grant_any && bus.req_valid[scan_idx[PTR_W-1:0]]) begin
          grant_any = 1'b1;
          grant_idx = scan_idx[PTR_W-1:0];
        end
      end
    end
  end

  generate
    for (gi = 0; gi < N_FU; gi++) begin : g_ack
      assign grant_oh[gi] = grant_any && (grant_idx == PTR_W'(gi));
    end
  endgenerate

  // AND-OR mux on the one-hot grant; avoids a variable part-select.
  always_comb begin
    sel_result = '0;
    sel_tag    = '0;
    sel_dest   = '0;
    for (int i = 0; i < N_FU; i++) begin
      if (grant_oh[i]) begin
        sel_result = sel_result | fu_result[i];
        sel_tag    = sel_tag    | fu_tag[i];
        sel_dest   = sel_dest   | fu_dest[i];
      end
    end
  end

  // Next-state: broadcast the winner; on no grant drop valid and keep the
  // last data so the bus does not toggle needlessly.
  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    cdb_valid_d  = grant_any;
    cdb_result_d = cdb_result_q;
    cdb_tag_d    = cdb_tag_q;
    cdb_dest_d   = cdb_dest_q;
    if (grant_any) begin
      cdb_result_d = sel_result;
      cdb_tag_d    = sel_tag;
      cdb_dest_d   = sel_dest;
      rr_ptr_d     = (grant_idx == LAST_FU) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q     <= '0;
      cdb_valid_q  <= 1'b0;
      cdb_result_q <= '0;
      cdb_tag_q    <= '0;
      cdb_dest_q   <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      cdb_valid_q  <= cdb_valid_d;
      cdb_result_q <= cdb_result_d;
      cdb_tag_q    <= cdb_tag_d;
      cdb_dest_q   <= cdb_dest_d;
    end
  end

  assign bus.req_ack      = grant_oh;
  assign bus.cdb_valid    = cdb_valid_q;
  assign bus.cdb_result   = cdb_result_q;
  assign bus.cdb_tag      = cdb_tag_q;
  assign bus.cdb_dest_reg = cdb_dest_q;

endmodule : cdb_arbiter

// File: tb/tb_cdb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cdb_arbiter
//
// Purpose:
//   Self-checking bench for cdb_arbiter. A table of per-cycle vectors
//   (reset, requests, stall, flush, expected ack, expected cdb_valid) covers
//   the directed scenarios; expected broadcasts are pushed to a queue when an
//   ack is expected and popped when cdb_valid is seen. A randomized phase
//   then checks fairness and the per-cycle invariants.
// ---------------------------------------------------------------------------
module tb_cdb_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int TW = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cdb_arbiter_if #(.N_FU(N), .DATA_WIDTH(DW), .TAG_WIDTH(TW)) bus ();

  cdb_arbiter #(.N_FU(N), .DATA_WIDTH(DW), .TAG_WIDTH(TW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Per-FU payload, packed onto the flat buses.
  logic [DW-1:0] fu_res [N];
  logic [TW-1:0] fu_tag [N];
  logic [4:0]    fu_dst [N];

  always_comb begin
    bus.req_result = '0;
    bus.req_tag    = '0;
    bus.req_dest   = '0;
    for (int i = 0; i < N; i++) begin
      bus.req_result[i*DW +: DW] = fu_res[i];
      bus.req_tag[i*TW +: TW]    = fu_tag[i];
      bus.req_dest[i*5 +: 5]     = fu_dst[i];
    end
  end

  typedef struct {
    logic         rst;
    logic [N-1:0] rv;
    logic         stall;
    logic         flush;
    logic [N-1:0] ack;
    logic         vld;
  } vec_t;

  typedef struct {
    logic [DW-1:0] res;
    logic [TW-1:0] tag;
    logic [4:0]    dst;
  } bc_t;

  vec_t vecs[$];
  bc_t  sbq[$];
  bc_t  last_bc;
  logic prev_grant;
  int   n_checks;
  int   n_pass;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic add(input logic r, input logic [N-1:0] rv, input logic st,
                     input logic fl, input logic [N-1:0] ack, input logic vld);
    vec_t v;
    v.rst = r; v.rv = rv; v.stall = st; v.flush = fl; v.ack = ack; v.vld = vld;
    vecs.push_back(v);
  endtask

  task automatic push_fu(input int idx);
    bc_t e;
    e.res = fu_res[idx];
    e.tag = fu_tag[idx];
    e.dst = fu_dst[idx];
    sbq.push_back(e);
  endtask

  // Registered-output scoreboard plus the per-cycle ack invariants.
  task automatic sample_cycle();
    bc_t e;
    if (bus.cdb_valid === 1'b1) begin
      check("valid_after_grant", {63'd0, prev_grant}, 64'd1);
      if (sbq.size() == 0) begin
        check("unexpected_bcast", 64'd1, 64'd0);
      end else begin
        e = sbq.pop_front();
        check("cdb_result", {32'd0, bus.cdb_result}, {32'd0, e.res});
        check("cdb_tag", {61'd0, bus.cdb_tag}, {61'd0, e.tag});
        check("cdb_dest_reg", {59'd0, bus.cdb_dest_reg}, {59'd0, e.dst});
        last_bc = e;
      end
      $display("bcast tag=%0d dest=%0d result=%08h", bus.cdb_tag, bus.cdb_dest_reg, bus.cdb_result);
    end else begin
      if (sbq.size() != 0) begin
        check("missing_bcast", 64'(sbq.size()), 64'd0);
        sbq.delete();
      end
      check("held_result", {32'd0, bus.cdb_result}, {32'd0, last_bc.res});
      check("held_tag", {61'd0, bus.cdb_tag}, {61'd0, last_bc.tag});
      check("held_dest", {59'd0, bus.cdb_dest_reg}, {59'd0, last_bc.dst});
    end
    check("ack_onehot0", {63'd0, $onehot0(bus.req_ack)}, 64'd1);
    check("ack_subset", {63'd0, ((bus.req_ack & ~bus.req_valid) == '0)}, 64'd1);
    prev_grant = |bus.req_ack;
  endtask

  int           wait_cnt [N];
  logic [N-1:0] pending;

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    prev_grant = 1'b0;
    last_bc    = '{res: '0, tag: '0, dst: '0};
    fu_res[0] = 32'h1111_0000; fu_tag[0] = 3'd1; fu_dst[0] = 5'd3;
    fu_res[1] = 32'hA5A5_0101; fu_tag[1] = 3'd2; fu_dst[1] = 5'd12;
    fu_res[2] = 32'hDEAD_BEEF; fu_tag[2] = 3'd5; fu_dst[2] = 5'd7;
    fu_res[3] = 32'h0BAD_F00D; fu_tag[3] = 3'd6; fu_dst[3] = 5'd31;

    rst = 1'b1;
    bus.req_valid = '0;
    bus.cdb_stall = 1'b0;
    bus.flush     = 1'b0;
    repeat (2) @(posedge clk);

    // Reset state
    @(negedge clk); #1;
    check("rst_cdb_valid", {63'd0, bus.cdb_valid}, 64'd0);
    check("rst_cdb_result", {32'd0, bus.cdb_result}, 64'd0);
    check("rst_cdb_tag", {61'd0, bus.cdb_tag}, 64'd0);
    check("rst_cdb_dest", {59'd0, bus.cdb_dest_reg}, 64'd0);

    //  rst  req_valid stall flush  ack      vld
    add(1, 4'b1111, 0, 0, 4'b0000, 0); // ack held off during reset
    add(0, 4'b0000, 0, 0, 4'b0000, 0);
    // single request, FU2 (rr -> 3)
    add(0, 4'b0100, 0, 0, 4'b0100, 0);
    add(0, 4'b0000, 0, 0, 4'b0000, 1);
    add(0, 4'b0000, 0, 0, 4'b0000, 0);
    // wrap-around from rr=3
    add(0, 4'b1001, 0, 0, 4'b1000, 0);
    add(0, 4'b0001, 0, 0, 4'b0001, 1);
    add(0, 4'b0011, 0, 0, 4'b0010, 1); // rr=1 after the wrap
    add(0, 4'b0001, 0, 0, 4'b0001, 1);
    add(0, 4'b0000, 0, 0, 4'b0000, 1);
    add(0, 4'b0000, 0, 0, 4'b0000, 0);
    // contention after reset
    add(1, 4'b0000, 0, 0, 4'b0000, 0);
    add(0, 4'b1111, 0, 0, 4'b0001, 0);
    add(0, 4'b1110, 0, 0, 4'b0010, 1);
    add(0, 4'b1100, 0, 0, 4'b0100, 1);
    add(0, 4'b1000, 0, 0, 4'b1000, 1);
    add(0, 4'b0000, 0, 0, 4'b0000, 1);
    add(0, 4'b1111, 0, 0, 4'b0001, 0); // rr back at 0
    add(0, 4'b1110, 0, 0, 4'b0010, 1);
    add(0, 4'b1100, 0, 0, 4'b0100, 1);
    add(0, 4'b1000, 0, 0, 4'b1000, 1);
    add(0, 4'b0000, 0, 0, 4'b0000, 1);
    add(0, 4'b0000, 0, 0, 4'b0000, 0);
    // stall for 3 cycles
    add(0, 4'b0010, 1, 0, 4'b0000, 0);
    add(0, 4'b0010, 1, 0, 4'b0000, 0);
    add(0, 4'b0010, 1, 0, 4'b0000, 0);
    add(0, 4'b0010, 0, 0, 4'b0010, 0);
    add(0, 4'b0000, 0, 0, 4'b0000, 1);
    add(0, 4'b0000, 0, 0, 4'b0000, 0);
    // registered broadcast survives a stall (rr=2, wraps to FU0)
    add(0, 4'b0001, 0, 0, 4'b0001, 0);
    add(0, 4'b0000, 1, 0, 4'b0000, 1);
    add(0, 4'b0000, 0, 0, 4'b0000, 0);
    // flush blocks the grant, then reset while a broadcast is valid
    add(0, 4'b0010, 0, 1, 4'b0000, 0);
    add(0, 4'b0010, 0, 0, 4'b0010, 0);
    add(1, 4'b0000, 0, 0, 4'b0000, 1);
    add(0, 4'b0000, 0, 0, 4'b0000, 0); // all outputs zero
    // flush beats stall and requests; flush kills the next broadcast slot
    add(0, 4'b0100, 1, 1, 4'b0000, 0);
    add(0, 4'b0100, 0, 0, 4'b0100, 0);
    add(0, 4'b1000, 0, 1, 4'b0000, 1);
    add(0, 4'b1000, 0, 0, 4'b1000, 0);
    add(0, 4'b0000, 0, 0, 4'b0000, 1);
    add(0, 4'b0000, 0, 0, 4'b0000, 0);

    for (int v = 0; v < vecs.size(); v++) begin
      @(negedge clk);
      rst           = vecs[v].rst;
      bus.req_valid = vecs[v].rv;
      bus.cdb_stall = vecs[v].stall;
      bus.flush     = vecs[v].flush;
      #1;
      check($sformatf("v%0d_cdb_valid", v), {63'd0, bus.cdb_valid}, {63'd0, vecs[v].vld});
      sample_cycle();
      check($sformatf("v%0d_req_ack", v), {60'd0, bus.req_ack}, {60'd0, vecs[v].ack});
      for (int i = 0; i < N; i++) begin
        if (vecs[v].ack[i]) push_fu(i);
      end
      if (vecs[v].rst) last_bc = '{res: '0, tag: '0, dst: '0};
    end

    // Randomized phase: requests held until acked, random stalls; every
    // request must be acked within N non-stalled cycles.
    pending = '0;
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (!pending[i] && ($urandom_range(0, 1) == 1)) begin
          pending[i] = 1'b1;
          fu_res[i]  = $urandom;
          fu_tag[i]  = TW'($urandom_range(0, 7));
          fu_dst[i]  = 5'($urandom_range(0, 31));
        end
      end
      rst           = 1'b0;
      bus.req_valid = pending;
      bus.cdb_stall = ($urandom_range(0, 3) == 0);
      bus.flush     = 1'b0;
      #1;
      sample_cycle();
      if (bus.cdb_stall) check("stall_no_ack", {60'd0, bus.req_ack}, 64'd0);
      for (int i = 0; i < N; i++) begin
        if (pending[i] && !bus.cdb_stall) wait_cnt[i]++;
        if (bus.req_ack[i] === 1'b1) begin
          check($sformatf("fair_fu%0d", i), {63'd0, (wait_cnt[i] <= N)}, 64'd1);
          push_fu(i);
          pending[i]  = 1'b0;
          wait_cnt[i] = 0;
        end else if (pending[i] && wait_cnt[i] == N + 1) begin
          check($sformatf("starved_fu%0d", i), 64'(wait_cnt[i]), 64'(N));
        end
      end
    end

    // Drain the last broadcast.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      bus.req_valid = '0;
      bus.cdb_stall = 1'b0;
      #1;
      sample_cycle();
    end
    check("sb_empty", 64'(sbq.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_cdb_arbiter
